// File: rtl/uart_tx_pkg.sv
// Shared UART constants and FSM encoding, used by both ends of the serial link.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uart_tx_pkg;

`ifdef SIM
    localparam bit UART_SIM = 1'b1;
`else
    localparam bit UART_SIM = 1'b0;
`endif

    localparam int UART_FPGA_FREQ    = 50_000_000;
    localparam int UART_BAUD_RATE    = 9600;
    // 50 MHz / 9600 baud, truncated: 5208 clocks per bit on the board
    localparam int UART_BAUD_END_HW  = UART_FPGA_FREQ / UART_BAUD_RATE;
    // Short bit time so simulation frames stay a few hundred cycles long
    localparam int UART_BAUD_END_SIM = 56;
    localparam int UART_BAUD_END     = UART_SIM ? UART_BAUD_END_SIM : UART_BAUD_END_HW;

    localparam int UART_BAUD_CNT_W   = 13;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BAUD_END-1 while enabled, ticks o_bit_end on the last count.
// Latency: o_bit_end is combinational from the count; the count restarts at 0 after each tick.
// Backpressure: none; held at 0 whenever i_en is low.
module uart_baud_cnt
    import uart_tx_pkg::*;
#(
    parameter int BAUD_END = UART_BAUD_END
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_bit_end
);

    localparam logic [UART_BAUD_CNT_W-1:0] LAST = UART_BAUD_CNT_W'(BAUD_END - 1);

    logic [UART_BAUD_CNT_W-1:0] r_cnt;

    // Free-run across bit boundaries while enabled so every bit is exactly BAUD_END clocks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!i_en || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_bit_end = i_en && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1/8N2, LSB first, with a one-byte holding register for gapless frames.
// Latency: tx drops to the start bit the cycle after the accepting handshake.
// Backpressure: tx_ready = holding register empty; at most one byte waits behind the frame in flight.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ  = UART_FPGA_FREQ,
    parameter int BAUD_RATE = UART_BAUD_RATE,
    parameter int BAUD_END  = ((CLK_FREQ == UART_FPGA_FREQ) && (BAUD_RATE == UART_BAUD_RATE))
                              ? UART_BAUD_END : (CLK_FREQ / BAUD_RATE),
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    // Anything other than 2 is treated as a single stop bit
    localparam logic [3:0] LAST_STOP = (STOP_BITS == 2) ? 4'd1 : 4'd0;
    localparam logic [3:0] LAST_DATA = 4'(UART_DATA_BITS - 1);

    uart_state_t r_state;
    logic [7:0]  r_shift;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_hold;
    logic        r_hold_full;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;

    logic        w_bit_end;
    logic        w_hs;
    logic        w_last_bit;

    uart_baud_cnt #(
        .BAUD_END (BAUD_END)
    ) u_baud_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_en      (r_busy),
        .o_bit_end (w_bit_end)
    );

    assign w_hs       = tx_valid && !r_hold_full;
    assign w_last_bit = (r_state == ST_STOP) && w_bit_end && (r_bit_cnt == LAST_STOP);

    assign tx_ready = ~r_hold_full;
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign tx_done  = r_done;

    // Frame FSM, shifter and holding register; the line only moves on bit boundaries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_shift <= tx_data;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_cnt <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == LAST_DATA) begin
                            r_tx      <= 1'b1;
                            r_bit_cnt <= '0;
                            r_state   <= ST_STOP;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_last_bit) begin
                        r_done    <= 1'b1;
                        r_bit_cnt <= '0;
                        if (r_hold_full) begin
                            // Pending byte follows with no idle gap
                            r_shift     <= r_hold;
                            r_hold_full <= 1'b0;
                            r_tx        <= 1'b0;
                            r_state     <= ST_START;
                        end else if (tx_valid) begin
                            // Byte offered on the very last cycle goes straight to the shifter
                            r_shift <= tx_data;
                            r_tx    <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_bit_end) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase

            // Mid-frame handshakes park the byte until the current frame ends
            if (r_busy && w_hs && !w_last_bit) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx with a frame-level line model and a line decoder.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx;

    localparam int B  = 56;
    localparam int FL = 10 * B;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx, busy, tx_done;

    logic [7:0] tx_data2  = 8'h00;
    logic       tx_valid2 = 1'b0;
    logic       tx_ready2, tx2, busy2, tx_done2;

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_FREQ  (50_000_000),
        .BAUD_RATE (9600),
        .BAUD_END  (B),
        .STOP_BITS (1)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    uart_tx #(
        .CLK_FREQ  (50_000_000),
        .BAUD_RATE (9600),
        .BAUD_END  (B),
        .STOP_BITS (2)
    ) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data2),
        .tx_valid (tx_valid2),
        .tx_ready (tx_ready2),
        .tx       (tx2),
        .busy     (busy2),
        .tx_done  (tx_done2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    bit         m_active    = 1'b0;
    bit         m_hold_full = 1'b0;
    bit         m_done      = 1'b0;
    int         m_off       = 0;
    logic [7:0] m_byte      = 8'h00;
    logic [7:0] m_hold      = 8'h00;
    logic [7:0] exp_q[$];
    int         n_acc  = 0;
    int         n_drop = 0;
    int         n_dec  = 0;

    bit         rx_on   = 1'b0;
    int         rx_t    = 0;
    logic [7:0] rx_byte = 8'h00;

    // Expected line level at a given cycle offset into a frame carrying b
    function automatic logic exp_line(input logic [7:0] b, input int off);
        int j;
        j = off / B;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        return 1'b1;
    endfunction

    initial begin
        logic [7:0] want;
        int         k;
        forever begin
            @(posedge clk);
            if (!rst) begin
                n_drop      += exp_q.size();
                exp_q.delete();
                m_active    = 1'b0;
                m_hold_full = 1'b0;
                m_done      = 1'b0;
                m_off       = 0;
                rx_on       = 1'b0;
            end else begin
                m_done = 1'b0;
                if (!m_active) begin
                    if (tx_valid) begin
                        exp_q.push_back(tx_data);
                        n_acc++;
                        m_active = 1'b1;
                        m_off    = 0;
                        m_byte   = tx_data;
                    end
                end else if (m_off == FL - 1) begin
                    m_done = 1'b1;
                    m_off  = 0;
                    if (m_hold_full) begin
                        m_hold_full = 1'b0;
                        m_byte      = m_hold;
                    end else if (tx_valid) begin
                        exp_q.push_back(tx_data);
                        n_acc++;
                        m_byte = tx_data;
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_off++;
                    if (tx_valid && !m_hold_full) begin
                        exp_q.push_back(tx_data);
                        n_acc++;
                        m_hold      = tx_data;
                        m_hold_full = 1'b1;
                    end
                end
            end
            #1;
            check("tx",       tx,       m_active ? exp_line(m_byte, m_off) : 1'b1);
            check("busy",     busy,     m_active);
            check("tx_ready", tx_ready, !m_hold_full);
            check("tx_done",  tx_done,  m_done);

            // Independent line decoder: sample mid-bit, compare against accepted order
            if (rst) begin
                if (!rx_on) begin
                    if (tx === 1'b0) begin
                        rx_on = 1'b1;
                        rx_t  = 0;
                    end
                end else begin
                    rx_t++;
                    if (rx_t == B / 2) check("rx_start", tx, 1'b0);
                    if ((rx_t > B / 2) && ((rx_t - B / 2) % B == 0) && (rx_t < B / 2 + 9 * B)) begin
                        k = (rx_t - B / 2) / B - 1;
                        rx_byte[k] = tx;
                    end
                    if (rx_t == B / 2 + 9 * B) begin
                        check("rx_stop", tx, 1'b1);
                        if (exp_q.size() == 0) begin
                            check("rx_extra", 32'd1, 32'd0);
                        end else begin
                            want = exp_q.pop_front();
                            check("rx_byte", rx_byte, want);
                        end
                        n_dec++;
                        rx_on = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Offer b and return on the negedge after it has been taken; tx_valid is left high
    task automatic send(input logic [7:0] b);
        int n;
        tx_data  = b;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("send_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tx_valid = 1'b0;
        while ((m_active || m_hold_full) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("idle_timeout", 32'd1, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_off(input int off);
        int n;
        n = 0;
        while (!(m_active && m_off == off) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("off_timeout", 32'd1, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, lo, hi, nb;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        check("rst_tx",     tx,        1'b1);
        check("rst_ready",  tx_ready,  1'b1);
        check("rst_busy",   busy,      1'b0);
        check("rst_done",   tx_done,   1'b0);
        check("rst_ready2", tx_ready2, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 0x55: start bit right after the handshake, done 560 cycles later
        send(8'h55);
        tx_valid = 1'b0;
        check("start_lat", tx, 1'b0);
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (tx_done) break;
        end
        check("len_55",    n,    FL);
        check("idle_tx",   tx,   1'b1);
        check("idle_busy", busy, 1'b0);
        wait_idle();

        // tx_valid held across two bytes
        send(8'hA3);
        send(8'h0F);
        check("ready_drop", tx_ready, 1'b0);
        wait_idle();

        // three bytes offered during one frame
        send(8'($urandom));
        send(8'($urandom));
        tx_data = 8'($urandom);
        @(negedge clk);
        check("ready_full", tx_ready, 1'b0);
        send(tx_data);
        wait_idle();

        // byte offered exactly on the last stop-bit cycle with the hold empty
        send(8'($urandom));
        tx_valid = 1'b0;
        wait_off(FL - 1);
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("gapless_busy", busy,    1'b1);
        check("gapless_tx",   tx,      1'b0);
        check("gapless_done", tx_done, 1'b1);
        wait_idle();

        // reset mid-frame with a byte held
        send(8'hFF);
        send(8'($urandom));
        tx_valid = 1'b0;
        wait_off(300);
        rst = 1'b0;
        #1;
        check("mrst_tx",    tx,       1'b1);
        check("mrst_ready", tx_ready, 1'b1);
        check("mrst_busy",  busy,     1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mrst_done", tx_done, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        send(8'($urandom));
        wait_idle();

        // randomised gaps and bursts
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(0, FL + 50);
            tx_valid = 1'b0;
            repeat (n) @(negedge clk);
            nb = $urandom_range(1, 3);
            for (int j = 0; j < nb; j++) send(8'($urandom));
            tx_valid = 1'b0;
        end
        wait_idle();

        // two stop bits, 0x00
        tx_data2  = 8'h00;
        tx_valid2 = 1'b1;
        @(negedge clk);
        tx_valid2 = 1'b0;
        check("sb2_start", tx2, 1'b0);
        lo = 1;
        while (lo < 2000) begin
            @(posedge clk);
            #1;
            if (tx2 !== 1'b0) break;
            lo++;
        end
        hi = 1;
        while (hi < 2000) begin
            @(posedge clk);
            #1;
            if (tx_done2) break;
            hi++;
        end
        check("sb2_low",   lo,      9 * B);
        check("sb2_high",  hi,      2 * B);
        check("sb2_frame", lo + hi, 11 * B);
        check("sb2_busy",  busy2,   1'b0);
        check("sb2_tx",    tx2,     1'b1);

        check("dec_count", n_dec, n_acc - n_drop);
        check("q_empty",   exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
